// File: rtl/fp_unpack_ctrl.sv
// Operand-pair unpacker: one shared classifier splits two IEEE-style operands
// into sign / signed exponent / mantissa / one-hot class, A then B.
module fp_unpack_ctrl #(
    parameter int unsigned N_EXP = 11,
    parameter int unsigned N_MAN = 52,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_EXP+N_MAN:0]    in_a,
    input  logic [N_EXP+N_MAN:0]    in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    a_sign,
    output logic                    b_sign,
    output logic signed [N_EXP+1:0] a_exp,
    output logic signed [N_EXP+1:0] b_exp,
    output logic [N_MAN:0]          a_man,
    output logic [N_MAN:0]          b_man,
    output logic [4:0]              a_cls,
    output logic [4:0]              b_cls,
    output logic [CNT_W-1:0]        spec_cnt
);

    localparam int unsigned W = N_EXP + N_MAN + 1;

    // One-hot class encoding {nan, inf, zero, dnorm, norm}
    localparam logic [4:0] ClsNan   = 5'b10000;
    localparam logic [4:0] ClsInf   = 5'b01000;
    localparam logic [4:0] ClsZero  = 5'b00100;
    localparam logic [4:0] ClsDnorm = 5'b00010;
    localparam logic [4:0] ClsNorm  = 5'b00001;

    localparam logic [N_EXP+1:0] Bias     = {2'b00, 1'b1, {(N_EXP-1){1'b0}}};
    localparam logic [N_EXP+1:0] ExpOne   = {{(N_EXP+1){1'b0}}, 1'b1};
    // Denormals carry the smallest normal exponent with an implicit leading 0
    localparam logic [N_EXP+1:0] DnormExp = ExpOne - Bias;

    typedef enum logic [1:0] {StIdle, StClsA, StClsB, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic             a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [N_EXP+1:0] a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [N_MAN:0]   a_man_q, a_man_d, b_man_q, b_man_d;
    logic [4:0]       a_cls_q, a_cls_d, b_cls_q, b_cls_d;
    logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;

    logic [W-1:0]     c_in;
    logic             c_sign;
    logic [N_EXP-1:0] c_expf;
    logic [N_MAN-1:0] c_manf;
    logic [N_EXP+1:0] c_exp;
    logic [N_MAN:0]   c_man;
    logic [4:0]       c_cls;

    // Shared classifier; its operand is selected by the FSM state
    always_comb begin
        c_in   = (state_q == StClsB) ? op_b_q : op_a_q;
        c_sign = c_in[W-1];
        c_expf = c_in[N_MAN +: N_EXP];
        c_manf = c_in[N_MAN-1:0];
        c_exp  = {2'b00, c_expf};
        c_man  = {1'b0, c_manf};
        c_cls  = ClsNorm;
        if (&c_expf) begin
            c_cls = (|c_manf) ? ClsNan : ClsInf;
        end else if (~|c_expf) begin
            if (|c_manf) begin
                c_cls = ClsDnorm;
                c_exp = DnormExp;
            end else begin
                c_cls = ClsZero;
            end
        end else begin
            c_exp = {2'b00, c_expf} - Bias;
            c_man = {1'b1, c_manf};
        end
    end

    // Next-state, operand capture, result registration and special counting
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        a_sign_d   = a_sign_q;
        a_exp_d    = a_exp_q;
        a_man_d    = a_man_q;
        a_cls_d    = a_cls_q;
        b_sign_d   = b_sign_q;
        b_exp_d    = b_exp_q;
        b_man_d    = b_man_q;
        b_cls_d    = b_cls_q;
        spec_cnt_d = spec_cnt_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_a_d  = in_a;
                        op_b_d  = in_b;
                        state_d = StClsA;
                    end
                end
                StClsA: begin
                    a_sign_d = c_sign;
                    a_exp_d  = c_exp;
                    a_man_d  = c_man;
                    a_cls_d  = c_cls;
                    state_d  = StClsB;
                end
                StClsB: begin
                    b_sign_d = c_sign;
                    b_exp_d  = c_exp;
                    b_man_d  = c_man;
                    b_cls_d  = c_cls;
                    state_d  = StDone;
                    if ((a_cls_q[4] | a_cls_q[3] | c_cls[4] | c_cls[3]) &&
                        (spec_cnt_q != {CNT_W{1'b1}})) begin
                        spec_cnt_d = spec_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_a_q     <= '0;
            op_b_q     <= '0;
            a_sign_q   <= 1'b0;
            a_exp_q    <= '0;
            a_man_q    <= '0;
            a_cls_q    <= '0;
            b_sign_q   <= 1'b0;
            b_exp_q    <= '0;
            b_man_q    <= '0;
            b_cls_q    <= '0;
            spec_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            a_sign_q   <= a_sign_d;
            a_exp_q    <= a_exp_d;
            a_man_q    <= a_man_d;
            a_cls_q    <= a_cls_d;
            b_sign_q   <= b_sign_d;
            b_exp_q    <= b_exp_d;
            b_man_q    <= b_man_d;
            b_cls_q    <= b_cls_d;
            spec_cnt_q <= spec_cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign a_sign    = a_sign_q;
    assign b_sign    = b_sign_q;
    assign a_exp     = $signed(a_exp_q);
    assign b_exp     = $signed(b_exp_q);
    assign a_man     = a_man_q;
    assign b_man     = b_man_q;
    assign a_cls     = a_cls_q;
    assign b_cls     = b_cls_q;
    assign spec_cnt  = spec_cnt_q;

endmodule

// File: tb/tb_fp_unpack_ctrl.sv
// Self-checking bench for fp_unpack_ctrl (binary64 layout) with a reference model.
module tb_fp_unpack_ctrl;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, out_ready;
    logic [63:0]        in_a, in_b;
    logic               in_ready, out_valid, a_sign, b_sign;
    logic signed [12:0] a_exp, b_exp;
    logic [52:0]        a_man, b_man;
    logic [4:0]         a_cls, b_cls;
    logic [15:0]        spec_cnt;

    logic               d2_in_ready, d2_out_valid, d2_a_sign, d2_b_sign;
    logic signed [12:0] d2_a_exp, d2_b_exp;
    logic [52:0]        d2_a_man, d2_b_man;
    logic [4:0]         d2_a_cls, d2_b_cls;
    logic [1:0]         d2_spec_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic        m_a_sign, m_b_sign;
    int          m_a_exp, m_b_exp;
    logic [52:0] m_a_man, m_b_man;
    logic [4:0]  m_a_cls, m_b_cls;
    int          m_cnt, m_cnt2;

    always #5 clk = ~clk;

    fp_unpack_ctrl #(.N_EXP(11), .N_MAN(52), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_man(a_man), .b_man(b_man), .a_cls(a_cls), .b_cls(b_cls), .spec_cnt(spec_cnt)
    );

    fp_unpack_ctrl #(.N_EXP(11), .N_MAN(52), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(d2_out_valid), .out_ready(out_ready),
        .a_sign(d2_a_sign), .b_sign(d2_b_sign), .a_exp(d2_a_exp), .b_exp(d2_b_exp),
        .a_man(d2_a_man), .b_man(d2_b_man), .a_cls(d2_a_cls), .b_cls(d2_b_cls),
        .spec_cnt(d2_spec_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Classification straight from the IEEE field rules
    function automatic void classify(input logic [63:0] x, output logic sgn,
                                     output logic [4:0] cls, output int e_out,
                                     output logic [52:0] m_out);
        int          e;
        logic [51:0] m;
        e   = int'(x[62:52]);
        m   = x[51:0];
        sgn = x[63];
        if (e == 2047) begin
            cls   = (m == 0) ? 5'b01000 : 5'b10000;
            e_out = e;
            m_out = {1'b0, m};
        end else if (e == 0) begin
            cls   = (m == 0) ? 5'b00100 : 5'b00010;
            e_out = 0;
            m_out = {1'b0, m};
        end else begin
            cls   = 5'b00001;
            e_out = e - 1024;
            m_out = (53'd1 << 52) + {1'b0, m};
        end
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] r;
        logic [10:0] e;
        int          sel;
        r   = {$urandom, $urandom};
        sel = $urandom_range(0, 3);
        e   = (sel == 0) ? 11'd0 : (sel == 1) ? 11'd2047 : 11'($urandom_range(1, 2046));
        if ($urandom_range(0, 1) == 0) r[51:0] = '0;
        return {r[63], e, r[51:0]};
    endfunction

    task automatic model_reset();
        m_a_sign = 0; m_b_sign = 0; m_a_exp = 0; m_b_exp = 0;
        m_a_man = '0; m_b_man = '0; m_a_cls = '0; m_b_cls = '0;
        m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".a_sign"}, 64'(a_sign), 64'(m_a_sign));
        chk({tag, ".a_cls"}, 64'(a_cls), 64'(m_a_cls));
        if (m_a_cls != 5'b00010) begin
            chk({tag, ".a_exp"}, 64'(a_exp), 64'(m_a_exp));
            chk({tag, ".a_man"}, 64'(a_man), 64'(m_a_man));
        end
        chk({tag, ".b_sign"}, 64'(b_sign), 64'(m_b_sign));
        chk({tag, ".b_cls"}, 64'(b_cls), 64'(m_b_cls));
        if (m_b_cls != 5'b00010) begin
            chk({tag, ".b_exp"}, 64'(b_exp), 64'(m_b_exp));
            chk({tag, ".b_man"}, 64'(b_man), 64'(m_b_man));
        end
        chk({tag, ".spec_cnt"}, 64'(spec_cnt), 64'(m_cnt));
        chk({tag, ".spec_cnt_w2"}, 64'(d2_spec_cnt), 64'(m_cnt2));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check_outs(tag);
    endtask

    // Full transaction; consumer stalls for 'hold' cycles in DONE
    task automatic run_pair(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input int hold);
        logic        sa, sb;
        logic [4:0]  ca, cb;
        int          ea, eb;
        logic [52:0] ma, mb;
        classify(a, sa, ca, ea, ma);
        classify(b, sb, cb, eb, mb);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = (hold == 0);
        chk({tag, ".accept_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, ".cls_a_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".cls_a_ready"}, 64'(in_ready), 64'd0);
        m_a_sign = sa; m_a_cls = ca; m_a_exp = ea; m_a_man = ma;
        tick();
        chk({tag, ".cls_b_valid"}, 64'(out_valid), 64'd0);
        m_b_sign = sb; m_b_cls = cb; m_b_exp = eb; m_b_man = mb;
        if (ca[4] || ca[3] || cb[4] || cb[3]) begin
            m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        tick();
        chk({tag, ".done_valid"}, 64'(out_valid), 64'd1);
        check_outs(tag);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
            check_outs({tag, ".hold"});
        end
        out_ready = 1'b1;
        tick();
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        model_reset();
        tick();
        do_reset("reset");

        run_pair("norm_zero", 64'h4000000000000000, 64'h0000000000000000, 0);
        chk("norm_zero.a_exp_lit", 64'(a_exp), 64'd0);
        chk("norm_zero.a_man_lit", 64'(a_man), 64'h10000000000000);
        run_pair("inf_nan", 64'h7FF0000000000000, 64'h7FF8000000000000, 0);
        chk("inf_nan.b_man_lit", 64'(b_man), 64'h8000000000000);
        chk("inf_nan.cnt_lit", 64'(spec_cnt), 64'd1);
        run_pair("stall", 64'hC008000000000000, 64'h3FF0000000000001, 5);

        // Flush while B is being classified: A registered, B and counter untouched
        in_a = 64'h7FF8000000000001; in_b = 64'hFFF0000000000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        classify(64'h7FF8000000000001, m_a_sign, m_a_cls, m_a_exp, m_a_man);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_b.valid", 64'(out_valid), 64'd0);
        chk("flush_b.ready", 64'(in_ready), 64'd1);
        check_outs("flush_b");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_b.no_valid", 64'(out_valid), 64'd0);
        end

        // Flush in IDLE blocks acceptance
        in_a = 64'h7FF0000000000000; in_b = 64'h7FF0000000000000;
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle.ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_idle.no_valid", 64'(out_valid), 64'd0);
        end
        check_outs("flush_idle");

        // Saturation of the narrow counter: expect 1,2,3,3
        do_reset("sat_reset");
        for (int i = 0; i < 4; i++) begin
            run_pair("sat", 64'h7FF0000000000000, 64'h3FF0000000000000, 0);
        end
        chk("sat.final_w2", 64'(d2_spec_cnt), 64'd3);
        chk("sat.final_w16", 64'(spec_cnt), 64'd4);

        // Reset mid-transaction in CLS_A discards the pair
        in_a = 64'h7FF0000000000000; in_b = 64'h7FF0000000000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        do_reset("rst_cls_a");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cls_a.no_valid", 64'(out_valid), 64'd0);
        end
        run_pair("dnorm", 64'h3FF0000000000000, 64'h0000000000000001, 0);
        chk("dnorm.b_cls_lit", 64'(b_cls), 64'b00010);

        for (int i = 0; i < 24; i++) begin
            run_pair("rand", rand_op(), rand_op(), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_unpack_ctrl.md
FP_UNPACK_CTRL -- requirements
Module: fp_unpack_ctrl

Interface
REQ-001 Parameter N_EXP, default 11, exponent field width.
REQ-002 Parameter N_MAN, default 52, stored mantissa field width.
REQ-003 Parameter CNT_W, default 16, special-operand counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 flush  in  1  synchronous abort of the in-flight transaction.
REQ-007 in_valid  in  1  operand pair valid.
REQ-008 in_ready  out  1  controller can accept a pair.
REQ-009 in_a, in_b  in  N_EXP+N_MAN+1 each  IEEE-style operands {sign, exp field, man field}.
REQ-010 out_valid  out  1  unpacked result pair valid.
REQ-011 out_ready  in  1  consumer accepts result.
REQ-012 a_sign, b_sign  out  1 each  operand sign bits.
REQ-013 a_exp, b_exp  out  N_EXP+2 each, signed  classified exponent.
REQ-014 a_man, b_man  out  N_MAN+1 each  classified mantissa.
REQ-015 a_cls, b_cls  out  5 each  one-hot {nan, inf, zero, dnorm, norm}.
REQ-016 spec_cnt  out  CNT_W  count of transactions with any NaN/Inf operand.

Function
REQ-017 Exactly one classifier datapath instance shall be time-shared between operands A and B; its input shall be driven through a mux selected by FSM state.
REQ-018 Classifier rules: exp field all-ones with man=0 -> inf; all-ones with man!=0 -> nan; exp field 0 with man=0 -> zero; exp field 0 with man!=0 -> dnorm; otherwise norm.
REQ-019 Norm: exp = exp field - 2^(N_EXP-1); man = {1, man field}. Nan/inf/zero: exp = zero-extended exp field; man = zero-extended man field. Dnorm: exp and man as produced by the shared classifier.
REQ-020 FSM states IDLE, CLS_A, CLS_B, DONE; reset state IDLE.
REQ-021 in_ready shall be 1 only in IDLE; IDLE -> CLS_A when in_valid=1, capturing in_a and in_b into operand registers.
REQ-022 CLS_A: classifier input = captured A; A results (sign, exp, man, cls) registered at cycle end; -> CLS_B.
REQ-023 CLS_B: classifier input = captured B; B results registered; -> DONE.
REQ-024 DONE: out_valid=1; outputs held stable until out_ready=1, then -> IDLE with out_valid=0 next cycle.
REQ-025 Latency: out_valid rises 3 cycles after the accepting edge; min issue interval 4 cycles with out_ready tied high.
REQ-026 spec_cnt shall increment by 1 on the CLS_B->DONE transition when A or B class is nan or inf; it shall saturate at 2^CNT_W-1.
REQ-027 flush=1 in any state: next state IDLE, out_valid=0, no spec_cnt increment for the aborted pair; result registers keep old values; flush in IDLE with in_valid=1 shall not accept.
REQ-028 rst has priority over flush; flush has priority over all handshake transitions.
REQ-029 out_* data shall change only on registration in CLS_A/CLS_B, never while out_valid=1.

Reset
REQ-030 On rst=1 at a rising edge: state IDLE, in_ready=1 next cycle, out_valid=0, all a_*/b_* outputs 0, spec_cnt 0, operand registers 0.
REQ-031 rst asserted mid-transaction shall discard it with no output and no counter update.

Verification (N_EXP=11, N_MAN=52)
REQ-032 A=0x4000000000000000, B=0x0000000000000000, out_ready=1 -> out_valid 3 cycles after accept; a_cls=norm, a_exp=0, a_man=0x10000000000000; b_cls=zero, b_exp=0, b_man=0; spec_cnt=0.
REQ-033 A=0x7FF0000000000000, B=0x7FF8000000000000 -> a_cls=inf, a_exp=2047, a_man=0; b_cls=nan, b_exp=2047, b_man=0x8000000000000; spec_cnt=1.
REQ-034 out_ready=0 for 5 cycles in DONE -> out_valid and all outputs stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 flush in CLS_B of a NaN pair -> out_valid never asserts, spec_cnt unchanged, in_ready=1 next cycle.
REQ-036 CNT_W=2, four back-to-back Inf pairs -> spec_cnt 1,2,3,3 (saturated).
REQ-037 rst pulse in CLS_A -> all outputs 0, IDLE; then B=0x0000000000000001 pair -> b_cls=dnorm.
